divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 77 +++++++
 1 files changed

// File: rtl/divider_seq.sv
// divider_seq: 16-by-8 unsigned restoring divider, one quotient bit per clock, MSB first
//   clk_system  rising-edge clock
//   rst_system  asynchronous active-low reset
//   start       request, honoured only in IDLE; P and B are captured with it
//   P, B        16-bit dividend, 8-bit divisor
//   busy        high while quotient bits are being produced
//   done        one-cycle pulse when Q/R/dz have just been updated
//   Q, R, dz    registered quotient, remainder and divide-by-zero flag
module divider_seq (
  input  logic        clk_system,
  input  logic        rst_system,
  input  logic        start,
  input  logic [15:0] P,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] dvd, quo;
  logic [7:0] dvs, rem, rem_n;
  logic [8:0] trial;
  logic [3:0] cnt;
  logic ge;
  always_ff @(posedge clk_system or negedge rst_system)
    if (!rst_system) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (start ? (B == 8'd0 ? DONE : RUN) : IDLE) :
              state == RUN  ? (cnt == 4'd0 ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // The remainder before the shift is always below the divisor, so after the
  // subtract it fits in 8 bits and the subtract can run modulo 256.
  always_comb begin
    trial = {rem, dvd[cnt]};
    ge = trial >= {1'b0, dvs};
    rem_n = trial[7:0] - (ge ? dvs : 8'd0);
  end
  always_ff @(posedge clk_system or negedge rst_system)
    if (!rst_system) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
      dz <= 1'b0;
    end else if (state == IDLE && start) begin
      if (B == 8'd0) begin
        Q <= 16'hFFFF;
        R <= 8'h00;
        dz <= 1'b1;
      end else begin
        dvd <= P;
        dvs <= B;
        rem <= '0;
        quo <= '0;
        cnt <= 4'd15;
      end
    end else if (state == RUN) begin
      rem <= rem_n;
      quo <= {quo[14:0], ge};
      cnt <= cnt - 4'd1;
      if (cnt == 4'd0) begin
        Q <= {quo[14:0], ge};
        R <= rem_n;
        dz <= 1'b0;
      end
    end
endmodule
